// File: rtl/hood_mode_scheduler.sv
// rtl/hood_mode_scheduler.sv - range-hood mode sequencing controller
//
// Turns the menu and mode buttons into the registered mode_state code for the
// smoker display and fan path. It also runs the timed rules:
//   - hurricane runs for a bounded time, once per power-on;
//   - a menu press in hurricane starts a return countdown;
//   - self-clean is a fixed-length job.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   power_on       machine on/off state; low forces idle and aborts jobs
//   menu_btn       debounced button level, rising edge acts
//   mode1_btn      debounced button level, rising edge acts
//   mode2_btn      debounced button level, rising edge acts
//   mode3_btn      debounced button level, rising edge acts
//   clean_btn      debounced button level, rising edge acts
//   mode_state     000 standby, 001 L1, 010 L2, 011 hurricane, 100 self-clean
//   menu_active    menu open, awaiting a mode selection
//   returning      hurricane return countdown running
//   remaining_sec  seconds left in the current timed state, else 0
//   hurricane_used hurricane entered since the last power-on
module hood_mode_scheduler #(
  parameter int CLK_FREQ      = 100000000,
  parameter int HURRICANE_SEC = 60,
  parameter int RETURN_SEC    = 60,
  parameter int CLEAN_SEC     = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       menu_btn,
  input  logic       mode1_btn,
  input  logic       mode2_btn,
  input  logic       mode3_btn,
  input  logic       clean_btn,
  output logic [2:0] mode_state,
  output logic       menu_active,
  output logic       returning,
  output logic [7:0] remaining_sec,
  output logic       hurricane_used
);

  localparam int            PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  // Timer loads saturate so an oversized parameter cannot wrap the 8-bit count.
  localparam logic [7:0] HUR_LOAD   = (HURRICANE_SEC > 255) ? 8'd255 : 8'(HURRICANE_SEC);
  localparam logic [7:0] RET_LOAD   = (RETURN_SEC > 255)    ? 8'd255 : 8'(RETURN_SEC);
  localparam logic [7:0] CLEAN_LOAD = (CLEAN_SEC > 255)     ? 8'd255 : 8'(CLEAN_SEC);

  localparam int B_MENU  = 0;
  localparam int B_MODE1 = 1;
  localparam int B_MODE2 = 2;
  localparam int B_MODE3 = 3;
  localparam int B_CLEAN = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MENU,
    S_L1,
    S_L2,
    S_L3,
    S_RET,
    S_CLEAN
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    btn_q, btn_d;
  logic [4:0]    press_raw, press;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    rem_q, rem_d;
  logic          hurricane_used_q, hurricane_used_d;
  logic [2:0]    mode_state_q, mode_state_d;
  logic          menu_active_q, menu_active_d;
  logic          returning_q, returning_d;
  logic          tick;
  logic          expire;

  // Edge detect plus priority: at most one press bit survives per cycle.
  always_comb begin
    btn_d     = {clean_btn, mode3_btn, mode2_btn, mode1_btn, menu_btn};
    press_raw = btn_d & ~btn_q;
    press     = '0;
    if (press_raw[B_MENU])       press[B_MENU]  = 1'b1;
    else if (press_raw[B_MODE3]) press[B_MODE3] = 1'b1;
    else if (press_raw[B_MODE2]) press[B_MODE2] = 1'b1;
    else if (press_raw[B_MODE1]) press[B_MODE1] = 1'b1;
    else if (press_raw[B_CLEAN]) press[B_CLEAN] = 1'b1;
  end

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    expire  = tick && (rem_q == 8'd1);
    state_d = state_q;

    case (state_q)
      S_IDLE: begin
        if (press[B_MENU]) state_d = S_MENU;
      end
      S_MENU: begin
        if (press[B_MENU])                             state_d = S_IDLE;
        else if (press[B_MODE1])                       state_d = S_L1;
        else if (press[B_MODE2])                       state_d = S_L2;
        else if (press[B_MODE3] && !hurricane_used_q)  state_d = S_L3;
        else if (press[B_CLEAN])                       state_d = S_CLEAN;
      end
      S_L1, S_L2: begin
        if (press[B_MENU])                             state_d = S_IDLE;
        else if (press[B_MODE1])                       state_d = S_L1;
        else if (press[B_MODE2])                       state_d = S_L2;
        else if (press[B_MODE3] && !hurricane_used_q)  state_d = S_L3;
      end
      S_L3: begin
        // A press on the expiry tick takes precedence over the drop to L2.
        if (press[B_MENU])       state_d = S_RET;
        else if (press[B_MODE1]) state_d = S_L1;
        else if (press[B_MODE2]) state_d = S_L2;
        else if (expire)         state_d = S_L2;
      end
      S_RET, S_CLEAN: begin
        if (expire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!power_on) state_d = S_IDLE;

    // Prescaler restarts on any state change so the first second is full length.
    if (!power_on) begin
      presc_d = '0;
      rem_d   = 8'd0;
    end else if (state_d != state_q) begin
      presc_d = '0;
      case (state_d)
        S_L3:    rem_d = HUR_LOAD;
        S_RET:   rem_d = RET_LOAD;
        S_CLEAN: rem_d = CLEAN_LOAD;
        default: rem_d = 8'd0;
      endcase
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      rem_d   = (tick && (rem_q != 8'd0)) ? rem_q - 8'd1 : rem_q;
    end

    hurricane_used_d = power_on && (hurricane_used_q || (state_d == S_L3));

    case (state_d)
      S_L1:         mode_state_d = 3'b001;
      S_L2:         mode_state_d = 3'b010;
      S_L3, S_RET:  mode_state_d = 3'b011;
      S_CLEAN:      mode_state_d = 3'b100;
      default:      mode_state_d = 3'b000;
    endcase
    menu_active_d = (state_d == S_MENU);
    returning_d   = (state_d == S_RET);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      btn_q            <= '0;
      presc_q          <= '0;
      rem_q            <= 8'd0;
      hurricane_used_q <= 1'b0;
      mode_state_q     <= 3'b000;
      menu_active_q    <= 1'b0;
      returning_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      btn_q            <= btn_d;
      presc_q          <= presc_d;
      rem_q            <= rem_d;
      hurricane_used_q <= hurricane_used_d;
      mode_state_q     <= mode_state_d;
      menu_active_q    <= menu_active_d;
      returning_q      <= returning_d;
    end
  end

  assign mode_state     = mode_state_q;
  assign menu_active    = menu_active_q;
  assign returning      = returning_q;
  assign remaining_sec  = rem_q;
  assign hurricane_used = hurricane_used_q;

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// tb/tb_hood_mode_scheduler.sv - self-checking bench for hood_mode_scheduler
module tb_hood_mode_scheduler;

  localparam int CF = 10;
  localparam int HS = 3;
  localparam int RS = 2;
  localparam int CS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       power_on = 1'b0;
  logic       menu_btn = 1'b0;
  logic       mode1_btn = 1'b0;
  logic       mode2_btn = 1'b0;
  logic       mode3_btn = 1'b0;
  logic       clean_btn = 1'b0;
  logic [2:0] mode_state;
  logic       menu_active;
  logic       returning;
  logic [7:0] remaining_sec;
  logic       hurricane_used;
  logic [13:0] dut_vec;

  always #5 clk = ~clk;

  hood_mode_scheduler #(
    .CLK_FREQ(CF), .HURRICANE_SEC(HS), .RETURN_SEC(RS), .CLEAN_SEC(CS)
  ) dut (
    .clk(clk), .rst(rst), .power_on(power_on),
    .menu_btn(menu_btn), .mode1_btn(mode1_btn), .mode2_btn(mode2_btn),
    .mode3_btn(mode3_btn), .clean_btn(clean_btn),
    .mode_state(mode_state), .menu_active(menu_active), .returning(returning),
    .remaining_sec(remaining_sec), .hurricane_used(hurricane_used)
  );

  assign dut_vec = {mode_state, menu_active, returning, remaining_sec, hurricane_used};

  int total = 0;
  int bad = 0;

  // Reference model: job kind plus cycles left until the job ends.
  localparam int K_IDLE = 0, K_MENU = 1, K_L1 = 2, K_L2 = 3, K_L3 = 4, K_RET = 5, K_CLEAN = 6;
  int       m_kind = K_IDLE;
  int       m_cl = 0;
  bit       m_used = 1'b0;
  bit [4:0] m_prev = '0;

  function automatic logic [13:0] mk(logic [2:0] m, logic ma, logic rt, logic [7:0] r, logic u);
    return {m, ma, rt, r, u};
  endfunction

  function automatic logic [13:0] m_out();
    logic [2:0] md;
    case (m_kind)
      K_L1:        md = 3'd1;
      K_L2:        md = 3'd2;
      K_L3, K_RET: md = 3'd3;
      K_CLEAN:     md = 3'd4;
      default:     md = 3'd0;
    endcase
    return mk(md, m_kind == K_MENU, m_kind == K_RET, 8'((m_cl + CF - 1) / CF), m_used);
  endfunction

  task automatic m_reset();
    m_kind = K_IDLE; m_cl = 0; m_used = 1'b0; m_prev = '0;
  endtask

  task automatic m_enter(int k);
    m_kind = k;
    case (k)
      K_L3:    m_cl = HS * CF;
      K_RET:   m_cl = RS * CF;
      K_CLEAN: m_cl = CS * CF;
      default: m_cl = 0;
    endcase
    if (k == K_L3) m_used = 1'b1;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic m_edge();
    bit [4:0] lv, pr;
    int p;
    lv = {clean_btn, mode3_btn, mode2_btn, mode1_btn, menu_btn};
    pr = lv & ~m_prev;
    m_prev = lv;
    p = -1;
    if (pr[0]) p = 0;
    else if (pr[3]) p = 3;
    else if (pr[2]) p = 2;
    else if (pr[1]) p = 1;
    else if (pr[4]) p = 4;
    if (!power_on) begin
      m_kind = K_IDLE; m_cl = 0; m_used = 1'b0;
      return;
    end
    case (m_kind)
      K_IDLE: if (p == 0) m_enter(K_MENU);
      K_MENU: begin
        if (p == 0) m_enter(K_IDLE);
        else if (p == 1) m_enter(K_L1);
        else if (p == 2) m_enter(K_L2);
        else if (p == 3 && !m_used) m_enter(K_L3);
        else if (p == 4) m_enter(K_CLEAN);
      end
      K_L1, K_L2: begin
        if (p == 0) m_enter(K_IDLE);
        else if (p == 1) m_enter(K_L1);
        else if (p == 2) m_enter(K_L2);
        else if (p == 3 && !m_used) m_enter(K_L3);
      end
      K_L3: begin
        if (p == 0) m_enter(K_RET);
        else if (p == 1) m_enter(K_L1);
        else if (p == 2) m_enter(K_L2);
        else if (m_cl == 1) m_enter(K_L2);
        else m_cl--;
      end
      default: begin
        if (m_cl == 1) m_enter(K_IDLE);
        else m_cl--;
      end
    endcase
  endtask

  task automatic cyc();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(int idx, logic v);
    case (idx)
      0: menu_btn = v;
      1: mode1_btn = v;
      2: mode2_btn = v;
      3: mode3_btn = v;
      default: clean_btn = v;
    endcase
  endtask

  task automatic push(int idx);
    set_btn(idx, 1'b1);
    cyc();
  endtask

  task automatic rel();
    menu_btn = 0; mode1_btn = 0; mode2_btn = 0; mode3_btn = 0; clean_btn = 0;
    cyc();
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (dut_vec !== 14'd0) begin
      bad++; $display("FAIL reset_state: got %h want %h", dut_vec, 14'd0);
    end
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_mode_select();
    power_on = 1'b1;
    cyc(); cyc();
    push(0);
    total++;
    if (dut_vec !== mk(3'd0, 1, 0, 8'd0, 0)) begin
      bad++; $display("FAIL menu_open: got %h want %h", dut_vec, mk(3'd0, 1, 0, 8'd0, 0));
    end
    rel();
    push(2);
    total++;
    if (dut_vec !== mk(3'd2, 0, 0, 8'd0, 0)) begin
      bad++; $display("FAIL select_l2: got %h want %h", dut_vec, mk(3'd2, 0, 0, 8'd0, 0));
    end
    rel();
    push(0);
    total++;
    if (dut_vec !== mk(3'd0, 0, 0, 8'd0, 0)) begin
      bad++; $display("FAIL l2_menu_idle: got %h want %h", dut_vec, mk(3'd0, 0, 0, 8'd0, 0));
    end
    rel();
  endtask

  task automatic test_hurricane();
    push(0); rel();
    push(3);
    total++;
    if (dut_vec !== mk(3'd3, 0, 0, 8'd3, 1)) begin
      bad++; $display("FAIL l3_entry: got %h want %h", dut_vec, mk(3'd3, 0, 0, 8'd3, 1));
    end
    rel();
    for (int i = 0; i < 28; i++) begin
      cyc();
      total++;
      if (dut_vec !== m_out()) begin
        bad++; $display("FAIL l3_run cycle %0d: got %h want %h", i, dut_vec, m_out());
      end
    end
    total++;
    if (dut_vec !== mk(3'd3, 0, 0, 8'd1, 1)) begin
      bad++; $display("FAIL l3_last_sec: got %h want %h", dut_vec, mk(3'd3, 0, 0, 8'd1, 1));
    end
    cyc();
    total++;
    if (dut_vec !== mk(3'd2, 0, 0, 8'd0, 1)) begin
      bad++; $display("FAIL l3_expiry: got %h want %h", dut_vec, mk(3'd2, 0, 0, 8'd0, 1));
    end
    push(0); rel();
    push(0); rel();
    push(3);
    total++;
    if (dut_vec !== mk(3'd0, 1, 0, 8'd0, 1)) begin
      bad++; $display("FAIL l3_one_shot: got %h want %h", dut_vec, mk(3'd0, 1, 0, 8'd0, 1));
    end
    rel();
    push(0); rel();
  endtask

  task automatic test_return();
    power_on = 1'b0;
    cyc();
    total++;
    if (dut_vec !== 14'd0) begin
      bad++; $display("FAIL power_clear: got %h want %h", dut_vec, 14'd0);
    end
    power_on = 1'b1;
    cyc();
    push(0); rel();
    push(3); rel();
    push(0);
    total++;
    if (dut_vec !== mk(3'd3, 0, 1, 8'd2, 1)) begin
      bad++; $display("FAIL ret_entry: got %h want %h", dut_vec, mk(3'd3, 0, 1, 8'd2, 1));
    end
    rel();
    for (int i = 0; i < 18; i++) begin
      cyc();
      total++;
      if (dut_vec !== m_out()) begin
        bad++; $display("FAIL ret_run cycle %0d: got %h want %h", i, dut_vec, m_out());
      end
    end
    cyc();
    total++;
    if (dut_vec !== mk(3'd0, 0, 0, 8'd0, 1)) begin
      bad++; $display("FAIL ret_expiry: got %h want %h", dut_vec, mk(3'd0, 0, 0, 8'd0, 1));
    end
  endtask

  task automatic test_clean();
    push(0); rel();
    push(4);
    total++;
    if (dut_vec !== mk(3'd4, 0, 0, 8'd4, 1)) begin
      bad++; $display("FAIL clean_entry: got %h want %h", dut_vec, mk(3'd4, 0, 0, 8'd4, 1));
    end
    rel();
    for (int i = 2; i <= 40; i++) begin
      menu_btn = ((i % 6) < 3);
      cyc();
      total++;
      if (dut_vec !== m_out()) begin
        bad++; $display("FAIL clean_run cycle %0d: got %h want %h", i, dut_vec, m_out());
      end
      if ((i % 10) == 0) begin
        total++;
        if (i < 40 && dut_vec !== mk(3'd4, 0, 0, 8'(4 - i / 10), 1)) begin
          bad++; $display("FAIL clean_sec at %0d: got %h want %h", i, dut_vec, mk(3'd4, 0, 0, 8'(4 - i / 10), 1));
        end else if (i == 40 && dut_vec !== mk(3'd0, 0, 0, 8'd0, 1)) begin
          bad++; $display("FAIL clean_expiry: got %h want %h", dut_vec, mk(3'd0, 0, 0, 8'd0, 1));
        end
      end
    end
    rel();
  endtask

  task automatic test_priority_hold();
    int changes;
    logic [2:0] prev;
    power_on = 1'b0; cyc();
    power_on = 1'b1; cyc();
    push(0); rel();
    mode1_btn = 1'b1; mode3_btn = 1'b1;
    cyc();
    total++;
    if (dut_vec !== mk(3'd3, 0, 0, 8'd3, 1)) begin
      bad++; $display("FAIL priority_m3: got %h want %h", dut_vec, mk(3'd3, 0, 0, 8'd3, 1));
    end
    rel();
    push(2);
    total++;
    if (dut_vec !== mk(3'd2, 0, 0, 8'd0, 1)) begin
      bad++; $display("FAIL l3_to_l2: got %h want %h", dut_vec, mk(3'd2, 0, 0, 8'd0, 1));
    end
    rel();
    mode1_btn = 1'b1;
    changes = 0;
    prev = mode_state;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (mode_state !== prev) changes++;
      prev = mode_state;
    end
    rel();
    total++;
    if (changes !== 1 || mode_state !== 3'd1) begin
      bad++; $display("FAIL hold_single: got changes=%0d mode=%0d want changes=1 mode=1", changes, mode_state);
    end
  endtask

  task automatic test_power_abort();
    push(0); rel();
    push(0); rel();
    push(4); rel();
    for (int i = 0; i < 5; i++) cyc();
    power_on = 1'b0;
    cyc();
    total++;
    if (dut_vec !== 14'd0) begin
      bad++; $display("FAIL power_abort: got %h want %h", dut_vec, 14'd0);
    end
    power_on = 1'b1;
    cyc();
  endtask

  task automatic test_reset_abort();
    push(0); rel();
    push(3); rel();
    for (int i = 0; i < 5; i++) cyc();
    total++;
    if (dut_vec !== mk(3'd3, 0, 0, 8'd3, 1)) begin
      bad++; $display("FAIL l3_before_reset: got %h want %h", dut_vec, mk(3'd3, 0, 0, 8'd3, 1));
    end
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (dut_vec !== 14'd0) begin
      bad++; $display("FAIL async_reset: got %h want %h", dut_vec, 14'd0);
    end
    m_reset();
    #1;
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(4) == 0) menu_btn = ~menu_btn;
      if ($urandom_range(4) == 0) mode1_btn = ~mode1_btn;
      if ($urandom_range(4) == 0) mode2_btn = ~mode2_btn;
      if ($urandom_range(4) == 0) mode3_btn = ~mode3_btn;
      if ($urandom_range(4) == 0) clean_btn = ~clean_btn;
      if (power_on) begin
        if ($urandom_range(149) == 0) power_on = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        power_on = 1'b1;
      end
      cyc();
      total++;
      if (dut_vec !== m_out()) begin
        bad++; $display("FAIL random cycle %0d: got %h want %h", i, dut_vec, m_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_select();
    test_hurricane();
    test_return();
    test_clean();
    test_priority_hold();
    test_power_abort();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hood_mode_scheduler.md
# hood_mode_scheduler

Sequencing controller for the range-hood fan datapath. It converts the menu and mode buttons into the registered `mode_state` code consumed by the smoker display/fan path, and enforces the timed rules:
- hurricane runs for a bounded time and is allowed once per power-on;
- hurricane shutdown is delayed by a return interval;
- self-clean is a fixed-length job.

It sits between the on/off control (`machine_state`) and the smoker/LED blocks, replacing ad-hoc mode decoding.

## Interface
- `CLK_FREQ`, default 100000000: clock cycles per one-second tick.
- `HURRICANE_SEC`, default 60: hurricane run time before automatic drop to level 2.
- `RETURN_SEC`, default 60: delay from menu press in hurricane to standby.
- `CLEAN_SEC`, default 180: self-clean duration.
- `clk`  in  1: system clock; all logic runs on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `power_on`  in  1: machine state from the on/off control; low forces the block idle.
- `menu_btn`, `mode1_btn`, `mode2_btn`, `mode3_btn`, `clean_btn`  in  1 each: debounced button levels; only rising edges act.
- `mode_state`  out  3: 000 standby, 001 level 1, 010 level 2, 011 level 3 (hurricane), 100 self-clean.
- `menu_active`  out  1: high while the menu is open and awaiting mode selection.
- `returning`  out  1: high during the hurricane return countdown.
- `remaining_sec`  out  8: seconds left in the current timed state, 0 otherwise.
- `hurricane_used`  out  1: hurricane has been entered since the last power-on.

## Operation
- Edge detection:
  - Each button is registered once.
  - A press is `btn & ~btn_q`.
  - Only one press is honoured per cycle. Priority is menu > mode3 > mode2 > mode1 > clean; lower-priority presses in the same cycle are discarded.
- States: IDLE, MENU, L1, L2, L3, RET, CLEAN.
- `mode_state` per state:
  - IDLE and MENU: 000.
  - L1: 001. L2: 010.
  - L3 and RET: 011.
  - CLEAN: 100.
- Transitions:
  - IDLE: menu goes to MENU. All other presses are ignored.
  - MENU:
    - mode1 goes to L1; mode2 goes to L2.
    - mode3 goes to L3 if `hurricane_used`=0, otherwise it is ignored and the block stays in MENU.
    - clean goes to CLEAN.
    - menu goes to IDLE.
  - L1/L2:
    - mode1 goes to L1; mode2 goes to L2.
    - mode3 goes to L3 under the same `hurricane_used` rule.
    - menu goes to IDLE immediately.
    - clean is ignored.
  - L3:
    - `remaining_sec` is loaded with `HURRICANE_SEC` on entry and `hurricane_used` is set.
    - Expiry goes to L2.
    - menu goes to RET, loading `RETURN_SEC`.
    - mode1/mode2 go to L1/L2.
  - RET: expiry goes to IDLE. All presses are ignored.
  - CLEAN: `CLEAN_SEC` is loaded on entry. Expiry goes to IDLE. All presses are ignored.
- Timer:
  - A prescaler counts 0..`CLK_FREQ`-1. Its wrap is a tick.
  - The prescaler clears on every state change, so the first second after entry is full length.
  - In timed states, `remaining_sec` decrements on each tick.
  - A tick while `remaining_sec`=1 performs the expiry transition; `remaining_sec` becomes the next state's load value, or 0.
  - `remaining_sec` is 0 in untimed states.
  - Load values above 255 saturate to 255 at elaboration; the decrement never wraps below 0.
- Power:
  - While `power_on`=0, the state is forced to IDLE, `remaining_sec`=0 and the prescaler=0, and all presses are ignored.
  - On the falling edge of `power_on`, `hurricane_used` clears.
  - Power loss mid-operation (L3, RET, CLEAN) aborts the job without completing it.

## Timing
- Reset (`rst`=0, async):
  - state IDLE, `mode_state`=000, `menu_active`=0, `returning`=0, `remaining_sec`=0, `hurricane_used`=0.
  - prescaler=0 and edge registers=0.
- All outputs are registered and are a function of the current state.
- Press latency: a button rising at cycle n (first high sample) changes the outputs after edge n+1. The n+1 edge registers `btn_q`, and the state updates on the same edge using the combinational press.
- Expiry: the output changes on the edge that completes the final tick, exactly `load × CLK_FREQ` cycles after entry.
- A press coinciding with an expiry tick: the press wins in L3 (menu→RET or mode1/2); expiry wins in RET/CLEAN.
- A held button produces exactly one press.

## Test plan
Bench parameters: `CLK_FREQ`=10, `HURRICANE_SEC`=3, `RETURN_SEC`=2, `CLEAN_SEC`=4.
- Mode selection: reset, `power_on`=1, press menu, press mode2 → `menu_active` 1 then 0, `mode_state`=010; press menu → 000.
- Hurricane expiry and one-shot rule:
  - menu, mode3 → `mode_state`=011, `remaining_sec`=3, `hurricane_used`=1.
  - After 30 cycles → 010, `remaining_sec`=0.
  - menu, menu, mode3 → stays MENU.
- Hurricane return: in L3, press menu → `returning`=1, `remaining_sec`=2, `mode_state` stays 011; after 20 cycles → 000, `returning`=0.
- Self-clean: menu, clean → 100 with `remaining_sec` 4,3,2,1 at 10-cycle spacing, then 000; menu presses during CLEAN have no effect.
- Priority and hold: in MENU, mode1 and mode3 rise in the same cycle → L3; holding mode1 for 50 cycles while in L2 yields a single switch to L1.
- Power and reset abort:
  - Drop `power_on` in CLEAN → 000, `remaining_sec`=0, `hurricane_used`=0.
  - Assert `rst` low mid-L3 → all outputs at reset values asynchronously, before the next clock edge.
